// File: rtl/apb_crc_engine.sv
// APB3 CRC accelerator: data words queue in a small FIFO and are folded into the CRC one byte per
// clock. Define CRC_REFLECT_EN for reflected (LSB-first) processing and a bit-reversed readout.
`timescale 1ns/1ps
module apb_crc_engine #(
    parameter int unsigned       CRC_W      = 8,
    parameter logic [CRC_W-1:0]  POLY       = CRC_W'(8'h07),
    parameter logic [CRC_W-1:0]  INIT       = '0,
    parameter logic [CRC_W-1:0]  XOR_OUT    = '0,
    parameter int unsigned       FIFO_DEPTH = 4
) (
    input  logic        p_clk_i,
    input  logic        p_rst_i,
    input  logic [31:0] p_dat_i,
    output logic [31:0] p_dat_o,
    input  logic        p_sel_i,
    input  logic        p_enable_i,
    input  logic        p_we_i,
    input  logic [31:0] p_adr_i,
    output logic        p_ready,
    output logic        p_slverr
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [3:0] AdrData   = 4'h0;
    localparam logic [3:0] AdrCrc    = 4'h4;
    localparam logic [3:0] AdrStatus = 4'h8;
    localparam logic [3:0] AdrCtrl   = 4'hC;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [31:0]        cur_data_q, cur_data_d;
    logic [1:0]         cur_last_q, cur_last_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [1:0]         bytes_q, bytes_d;

    logic [31:0]        fifo_data_q [FIFO_DEPTH];
    logic [31:0]        fifo_data_d [FIFO_DEPTH];
    logic [1:0]         fifo_len_q  [FIFO_DEPTH];
    logic [1:0]         fifo_len_d  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [3:0]         adr;
    logic               access;
    logic               data_wr, crc_rd, stat_rd, ctrl_rd, ctrl_wr, bad_acc;
    logic               fifo_full, fifo_empty, busy, drained;
    logic               push, pop, clr;
    logic [7:0]         cur_byte, fold_in;
    logic [CRC_W-1:0]   crc_out;
    logic [31:0]        cnt_ext;
    logic               unused_adr_bits;

    assign unused_adr_bits = ^p_adr_i[31:4];

    function automatic logic [CRC_W-1:0] fold_byte(input logic [CRC_W-1:0] crc,
                                                   input logic [7:0]       data);
        logic [CRC_W-1:0] c;
        c = crc ^ (CRC_W'(data) << (CRC_W - 8));
        for (int i = 0; i < 8; i++) begin
            c = c[CRC_W-1] ? ((c << 1) ^ POLY) : (c << 1);
        end
        return c;
    endfunction

    // Reset gates the access so p_ready/p_slverr stay low while held in reset.
    assign adr     = p_adr_i[3:0];
    assign access  = p_sel_i & p_enable_i & p_rst_i;
    assign data_wr = access &  p_we_i & (adr == AdrData);
    assign crc_rd  = access & ~p_we_i & (adr == AdrCrc);
    assign stat_rd = access & ~p_we_i & (adr == AdrStatus);
    assign ctrl_rd = access & ~p_we_i & (adr == AdrCtrl);
    assign ctrl_wr = access &  p_we_i & (adr == AdrCtrl);
    assign bad_acc = access & ~(data_wr | crc_rd | stat_rd | ctrl_rd | ctrl_wr);

    assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign busy       = (state_q == StRun);
    assign drained    = ~busy & fifo_empty;
    assign push       = data_wr & ~fifo_full;
    assign clr        = ctrl_wr & p_dat_i[8];
    assign cur_byte   = cur_data_q[{idx_q, 3'b000} +: 8];
    assign cnt_ext    = 32'(cnt_q);

`ifdef CRC_REFLECT_EN
    logic [CRC_W-1:0] crc_rev;

    always_comb begin
        fold_in = '0;
        crc_rev = '0;
        for (int i = 0; i < 8; i++) begin
            fold_in[i] = cur_byte[7-i];
        end
        for (int i = 0; i < CRC_W; i++) begin
            crc_rev[i] = crc_q[CRC_W-1-i];
        end
    end

    assign crc_out = crc_rev ^ XOR_OUT;
`else
    assign fold_in = cur_byte;
    assign crc_out = crc_q ^ XOR_OUT;
`endif

    // Engine: a pop on the last byte of a word keeps RUN going without a bubble cycle.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cur_data_d = cur_data_q;
        cur_last_d = cur_last_q;
        crc_d      = crc_q;
        pop        = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    idx_d   = 2'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                crc_d = fold_byte(crc_q, fold_in);
                if (idx_q == cur_last_q) begin
                    idx_d = 2'd0;
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            cur_data_d = fifo_data_q[rd_ptr_q];
            cur_last_d = fifo_len_q[rd_ptr_q];
        end
        if (clr) begin
            pop     = 1'b0;
            state_d = StIdle;
            idx_d   = 2'd0;
            crc_d   = INIT;
        end
    end

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_len_d  = fifo_len_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        bytes_d     = bytes_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = p_dat_i;
            fifo_len_d[wr_ptr_q]  = bytes_q;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (ctrl_wr && !p_dat_i[8]) begin
            bytes_d = p_dat_i[1:0];
        end
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_comb begin
        p_ready  = 1'b0;
        p_slverr = 1'b0;
        p_dat_o  = '0;
        if (access) begin
            p_ready = 1'b1;
            if (bad_acc) begin
                p_slverr = 1'b1;
            end else if (data_wr) begin
                p_ready = ~fifo_full;
            end else if (crc_rd) begin
                p_ready = drained;
                if (drained) begin
                    p_dat_o = 32'(crc_out);
                end
            end else if (stat_rd) begin
                p_dat_o = {24'b0, cnt_ext[3:0], 1'b0, fifo_empty, fifo_full, busy};
            end else if (ctrl_rd) begin
                p_dat_o = {30'b0, bytes_q};
            end
        end
    end

    always_ff @(posedge p_clk_i or negedge p_rst_i) begin
        if (!p_rst_i) begin
            state_q     <= StIdle;
            idx_q       <= 2'd0;
            cur_data_q  <= '0;
            cur_last_q  <= 2'd0;
            crc_q       <= INIT;
            bytes_q     <= 2'd0;
            fifo_data_q <= '{default: '0};
            fifo_len_q  <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cur_data_q  <= cur_data_d;
            cur_last_q  <= cur_last_d;
            crc_q       <= crc_d;
            bytes_q     <= bytes_d;
            fifo_data_q <= fifo_data_d;
            fifo_len_q  <= fifo_len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_apb_crc_engine.sv
// Self-checking bench for apb_crc_engine: randomized APB traffic against a message-level CRC model
// and a byte-count timing model; covers CRC_REFLECT_EN with the CRC-32/ISO-HDLC setup.
`timescale 1ns/1ps
module tb_apb_crc_engine;
`ifdef CRC_REFLECT_EN
    localparam int unsigned W     = 32;
    localparam logic [31:0] P     = 32'h04C11DB7;
    localparam logic [31:0] I     = 32'hFFFFFFFF;
    localparam logic [31:0] X     = 32'hFFFFFFFF;
    localparam logic [31:0] CHECK = 32'hCBF43926;
`else
    localparam int unsigned W     = 8;
    localparam logic [31:0] P     = 32'h07;
    localparam logic [31:0] I     = 32'h0;
    localparam logic [31:0] X     = 32'h0;
    localparam logic [31:0] CHECK = 32'hF4;
`endif
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel, en, we;
    logic [31:0] adr, wdata, rdata;
    logic        ready, slverr;

    int checks = 0;
    int errors = 0;

    // Model state: words waiting, bytes left in the word being processed, whole message bytes.
    int          q_len[$];
    logic [7:0]  msg[$];
    int          remaining;
    logic [1:0]  m_bytes;

    apb_crc_engine #(
        .CRC_W     (W),
        .POLY      (P[W-1:0]),
        .INIT      (I[W-1:0]),
        .XOR_OUT   (X[W-1:0]),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .p_clk_i   (clk),
        .p_rst_i   (rst_n),
        .p_dat_i   (wdata),
        .p_dat_o   (rdata),
        .p_sel_i   (sel),
        .p_enable_i(en),
        .p_we_i    (we),
        .p_adr_i   (adr),
        .p_ready   (ready),
        .p_slverr  (slverr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_crc();
        logic [31:0] c, r, mask;
        logic [7:0]  b, bb;
        logic        fb;
        mask = (32'd1 << W) - 32'd1;
        c = I;
        foreach (msg[k]) begin
            b = msg[k];
`ifdef CRC_REFLECT_EN
            for (int i = 0; i < 8; i++) bb[i] = b[7-i];
`else
            bb = b;
`endif
            for (int i = 7; i >= 0; i--) begin
                fb = c[W-1] ^ bb[i];
                c  = (c << 1) & mask;
                if (fb) c = c ^ P;
            end
        end
`ifdef CRC_REFLECT_EN
        r = '0;
        for (int i = 0; i < W; i++) r[i] = c[W-1-i];
        c = r;
`endif
        return (c ^ X) & mask;
    endfunction

    function automatic void expect_out(output logic e_rdy, output logic e_err,
                                       output logic [31:0] e_dat);
        logic [3:0] a;
        int         n;
        a = adr[3:0];
        n = q_len.size();
        e_rdy = 1'b0;
        e_err = 1'b0;
        e_dat = '0;
        if (sel && en && rst_n) begin
            e_rdy = 1'b1;
            if (we && a == 4'h0) begin
                e_rdy = (n < DEPTH);
            end else if (!we && a == 4'h4) begin
                e_rdy = (remaining == 0) && (n == 0);
                if (e_rdy) e_dat = ref_crc();
            end else if (!we && a == 4'h8) begin
                e_dat = {24'b0, 4'(n), 1'b0, n == 0, n == DEPTH, remaining > 0};
            end else if (!we && a == 4'hC) begin
                e_dat = {30'b0, m_bytes};
            end else if (!(we && a == 4'hC)) begin
                e_err = 1'b1;
            end
        end
    endfunction

    task automatic model_step();
        logic        r, e;
        logic [31:0] d;
        int          n;
        if (!rst_n) begin
            q_len.delete();
            msg.delete();
            remaining = 0;
            m_bytes   = 2'd0;
        end else begin
            expect_out(r, e, d);
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0 && q_len.size() > 0) remaining = q_len.pop_front();
            end else if (q_len.size() > 0) begin
                remaining = q_len.pop_front();
            end
            if (sel && en && we && r && !e && adr[3:0] == 4'h0) begin
                n = int'(m_bytes) + 1;
                q_len.push_back(n);
                for (int k = 0; k < n; k++) msg.push_back(wdata[8*k +: 8]);
            end
            if (sel && en && we && adr[3:0] == 4'hC) begin
                if (wdata[8]) begin
                    q_len.delete();
                    msg.delete();
                    remaining = 0;
                end else begin
                    m_bytes = wdata[1:0];
                end
            end
        end
    endtask

    initial begin
        remaining = 0;
        m_bytes   = 2'd0;
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    // Cycle compare: every output, every cycle, against the model.
    initial begin
        logic        r, e;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            expect_out(r, e, d);
            checks++;
            if (ready !== r || slverr !== e || rdata !== d) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t adr=%h we=%b: got ready=%b slverr=%b dat=%h, want ready=%b slverr=%b dat=%h",
                         $time, adr, we, ready, slverr, rdata, r, e, d);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic apb(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err, output int waits);
        logic done;
        sel   = 1'b1;
        en    = 1'b0;
        we    = w;
        adr   = a;
        wdata = d;
        waits = 0;
        done  = 1'b0;
        @(posedge clk);
        #1 en = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (ready) begin
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL apb_timeout adr=%h: got no ready, want ready within 200 cycles", a);
                    done = 1'b1;
                end
            end
        end
        rd  = rdata;
        err = slverr;
        @(posedge clk);
        #1;
        sel = 1'b0;
        en  = 1'b0;
        we  = 1'b0;
    endtask

    logic [31:0] v, crc_a;
    logic        e;
    int          w;
    int          stalls;

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        apb(1'b1, a, d, v, e, w);
    endtask

    task automatic rd(input logic [31:0] a);
        apb(1'b0, a, 32'h0, v, e, w);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        int          op, off, n;
        logic [31:0] d;
        rst_n = 1'b0;
        sel = 1'b0; en = 1'b0; we = 1'b0; adr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, no wait states.
        rd(32'h4);  check("rst_crc", v, 32'h0);     check("rst_crc_waits", w, 0);
        rd(32'h8);  check("rst_status", v, 32'h4);  check("rst_status_waits", w, 0);
        rd(32'hC);  check("rst_ctrl", v, 32'h0);    check("rst_ctrl_waits", w, 0);

        // "123456789" as 4+4+1 byte words; the CRC read must stall until drained.
        wr(32'hC, 32'h3);
        wr(32'h0, 32'h34333231);
        wr(32'h0, 32'h38373635);
        wr(32'hC, 32'h0);
        wr(32'h0, 32'h39);
        rd(32'h4);
        check("check_value", v, CHECK);
        check("model_pin", ref_crc(), CHECK);
        check("crc_read_stalled", 32'(w > 0), 32'h1);
        rd(32'h4);  check("crc_reread", v, CHECK);  check("crc_reread_waits", w, 0);

        // Fill the FIFO with 4-byte words until a DATA write sees back-pressure.
        wr(32'hC, 32'h100);
        wr(32'hC, 32'h3);
        stalls = 0;
        for (int k = 0; k < 12; k++) begin
            wr(32'h0, $urandom());
            if (w > 0) stalls++;
        end
        check("full_stall_seen", 32'(stalls > 0), 32'h1);
        rd(32'h4);  check("full_crc", v, ref_crc());

        // CLR in the middle of RUN.
        wr(32'hC, 32'h100);
        wr(32'hC, 32'h3);
        for (int k = 0; k < 4; k++) wr(32'h0, $urandom());
        wr(32'hC, 32'h100);
        rd(32'h8);  check("clr_status", v, 32'h4);
        rd(32'h4);  check("clr_crc", v, 32'h0);
        rd(32'hC);  check("clr_ctrl_kept", v, 32'h3);

        // Bad accesses complete at once with an error and change nothing.
        wr(32'hC, 32'h0);
        wr(32'h0, 32'hA5);
        rd(32'h4);  crc_a = v;  check("one_byte_crc", v, ref_crc());
        rd(32'h0);  check("rd_data_err", 32'(e), 32'h1);   check("rd_data_waits", w, 0);
        wr(32'h4, 32'h5A);  check("wr_crc_err", 32'(e), 32'h1);
        wr(32'h8, 32'h5A);  check("wr_status_err", 32'(e), 32'h1);
        rd(32'h2);  check("rd_off2_err", 32'(e), 32'h1);
        rd(32'h4);  check("crc_unchanged", v, crc_a);      check("crc_rd_noerr", 32'(e), 32'h0);
        rd(32'h8);  check("fifo_unchanged", v, 32'h4);

        // Randomized traffic; the cycle compare does the checking.
        for (int k = 0; k < 300; k++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: wr(($urandom() & 32'hFFFF_FFF0), $urandom());
                4: begin
                    d = $urandom() & ~32'h100;
                    if ($urandom_range(0, 7) == 0) d = d | 32'h100;
                    wr(32'hC, d);
                end
                5: rd(($urandom() & 32'hFFFF_FFF0) | 32'h4);
                6: rd(32'h8);
                7: rd(32'hC);
                8: begin
                    off = $urandom_range(0, 15);
                    if (off % 4 == 0) off = off | 1;
                    apb($urandom_range(0, 1) == 1, 32'(off), $urandom(), v, e, w);
                end
                default: begin
                    n = $urandom_range(0, 3);
                    repeat (n) @(posedge clk);
                    #1;
                end
            endcase
        end
        rd(32'h4);  check("random_final_crc", v, ref_crc());

        // Asynchronous reset in the middle of RUN, during an access.
        wr(32'hC, 32'h3);
        for (int k = 0; k < 3; k++) wr(32'h0, $urandom());
        sel = 1'b1; we = 1'b0; adr = 32'h8; wdata = '0;
        @(posedge clk);
        #1 en = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_ready", 32'(ready), 32'h0);
        check("rst_async_dat", rdata, 32'h0);
        sel = 1'b0; en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(32'h8);  check("post_rst_status", v, 32'h4);
        rd(32'hC);  check("post_rst_ctrl", v, 32'h0);
        rd(32'h4);  check("post_rst_crc", v, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_crc_engine.md
Name: apb_crc_engine

Overview:
- Parametrised APB3 slave CRC accelerator.
- CRC width, polynomial, init and output-XOR are parameters.
- Multi-byte data words are buffered in a small FIFO and processed one byte per clock by a serialising engine, with wait-state back-pressure and status reporting.
- Sits on the peripheral APB bus beside other lab peripherals; the CPU streams data and reads the final CRC.

Parameters:
CRC_W, 8, CRC width in bits (8..32)
POLY, 8'h07, generator polynomial, CRC_W bits, implicit top bit
INIT, 0, CRC register value after reset/clear, CRC_W bits
XOR_OUT, 0, value XORed into CRC on readout, CRC_W bits
FIFO_DEPTH, 4, data-word FIFO entries (power of 2, >=2)

Ports:
p_clk_i  in  1  clock, all logic on rising edge
p_rst_i  in  1  reset, asynchronous, active-low
p_dat_i  in  32  APB write data
p_dat_o  out  32  APB read data
p_sel_i  in  1  APB select
p_enable_i  in  1  APB enable (access phase)
p_we_i  in  1  APB write
p_adr_i  in  32  APB address, only [3:0] decoded
p_ready  out  1  APB ready
p_slverr  out  1  APB error

Behaviour:
- Register map, p_adr_i[3:0]:
  - 0x0 DATA (W): push word.
  - 0x4 CRC (R): final CRC, zero-extended.
  - 0x8 STATUS (R): bit0 busy, bit1 full, bit2 empty, bits[7:4] FIFO count.
  - 0xC CTRL (R/W): [1:0] BYTES-1; bit8 CLR, write-1, self-clearing, reads 0.
- Any other offset or wrong direction (read DATA, write CRC/STATUS): access completes with p_ready=1 and p_slverr=1, no side effect.
- p_ready and p_slverr are combinational and meaningful only when p_sel_i&p_enable_i; both are 0 otherwise and in reset. p_dat_o is 0 except on a completing read. No-wait accesses complete in the first access cycle.
- DATA write with FIFO full: p_ready=0 until a slot frees. Push and p_ready=1 happen in the same cycle. A pop in a full cycle does not allow a push that cycle.
- CRC read while FIFO non-empty or engine busy: p_ready=0 until the engine is IDLE and the FIFO is empty. Then p_dat_o = crc ^ XOR_OUT. A read does not modify the CRC.
- FIFO entry = {nbytes = CTRL.BYTES+1 sampled at push, data[31:0]}. Bytes are processed LSB lane first: byte0 = data[7:0].
- Engine FSM:
  - IDLE: if FIFO not empty, pop and go to RUN with idx=0.
  - RUN: each cycle fold byte[idx] into crc, MSB-first, non-reflected, 8 shift steps combinationally. idx++.
  - On the last byte: pop the next entry if available and stay RUN (no bubble); else go to IDLE.
- Busy = RUN.
- Latency: 1-byte word pushed into an empty FIFO gives an updated CRC 2 cycles after the push edge (pop cycle + 1 byte cycle). Throughput N cycles per N-byte word.
- CLR: same cycle flush FIFO, crc=INIT, FSM->IDLE, idx=0. An in-flight byte is discarded. CTRL.BYTES is kept.
- Reset (async assert, any state): crc=INIT, FIFO empty, FSM IDLE, CTRL=0 (1 byte/word). Stalled APB transfers are abandoned.
- FIFO count width is clog2(FIFO_DEPTH)+1 and saturates at FIFO_DEPTH. STATUS bits[7:4] truncate if wider.

Optional Feature:
- CRC_REFLECT_EN defined:
  - Each byte is bit-reversed before folding (LSB-first processing).
  - The full CRC_W result is bit-reversed before XOR_OUT on readout.
  - Gives CRC-32/ISO-HDLC with CRC_W=32, POLY=32'h04C11DB7, INIT=XOR_OUT=32'hFFFFFFFF.
- Undefined: non-reflected only, no reversal logic.

Test Plan:
- Reset then read CRC, STATUS, CTRL -> 0x00, 0x04 (empty), 0x0, with no wait states.
- Defaults, CTRL=0x3, write DATA 0x34333231, 0x38373635, then CTRL=0x0, write 0x39, read CRC -> 0xF4 (CRC-8 "123456789"). The read stalls until drained.
- Fill the FIFO (4 writes, BYTES=4) back-to-back, 5th write -> p_ready low >=1 cycle, completes after a pop, final CRC correct.
- Push 4 words, write CTRL bit8 mid-RUN -> STATUS=0x04 next cycle, CRC read = 0x00. CTRL[1:0] is unchanged.
- Read offset 0x0 and write offset 0x4 -> p_ready=1, p_slverr=1, CRC and FIFO unchanged. Assert p_rst_i low mid-RUN -> all state cleared immediately.
- With CRC_REFLECT_EN, CRC_W=32, POLY=04C11DB7, INIT=XOR_OUT=FFFFFFFF, stream "123456789" -> CRC read 0xCBF43926.
